// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg
//   Shared constants and types for the data-memory port arbiter.
//   Word width, arbiter state encoding, read-latency bounds and latency-counter width.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef REG_32_ADDR_LEN
`define REG_32_ADDR_LEN 5
`endif

package dmem_port_arbiter_pkg;
  localparam int WORD_LEN   = `WORD_LEN;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int LAT_CNT_W  = 2;  // enough for 0..RD_LAT_MAX-1

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CORE_RD = 2'd1,
    ST_HOST_RD = 2'd2
  } arb_state_e;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the core (MEM stage), host and memory-side signals of the arbiter.
//   Names are from the arbiter's point of view (i_ = into arbiter, o_ = out of it).
//   slave  : arbiter side
//   master : environment side (core, host and memory together)
interface dmem_port_arbiter_if #(parameter int ADDR_W = 10);
  import dmem_port_arbiter_pkg::*;

  // core
  logic                i_core_rd_en;
  logic                i_core_wr_en;
  logic [ADDR_W-1:0]   i_core_addr;
  logic [WORD_LEN-1:0] i_core_wdata;
  logic [WORD_LEN-1:0] o_core_rdata;
  logic                o_core_stall;
  // host
  logic                i_host_req;
  logic                i_host_we;
  logic [ADDR_W-1:0]   i_host_addr;
  logic [WORD_LEN-1:0] i_host_wdata;
  logic                o_host_gnt;
  logic                o_host_rvalid;
  logic [WORD_LEN-1:0] o_host_rdata;
  // memory
  logic                o_mem_en;
  logic                o_mem_we;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [WORD_LEN-1:0] o_mem_wdata;
  logic [WORD_LEN-1:0] i_mem_rdata;

  modport slave (
    input  i_core_rd_en, i_core_wr_en, i_core_addr, i_core_wdata,
    output o_core_rdata, o_core_stall,
    input  i_host_req, i_host_we, i_host_addr, i_host_wdata,
    output o_host_gnt, o_host_rvalid, o_host_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_core_rd_en, i_core_wr_en, i_core_addr, i_core_wdata,
    input  o_core_rdata, o_core_stall,
    output i_host_req, i_host_we, i_host_addr, i_host_wdata,
    input  o_host_gnt, o_host_rvalid, o_host_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter_lat_counter.sv
// dmem_lat_counter
//   Read-latency counter shared by both read-wait states.
//   i_clk/i_rst : clock, synchronous active-high reset
//   i_load      : read issued this cycle, restart at 0
//   i_run       : arbiter is in a read-wait state
//   o_done      : data arrives this cycle (RD_LAT cycles after issue)
module dmem_lat_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_done
);
  // Out-of-range latencies are clamped to the supported window.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [LAT_CNT_W-1:0] LAST = LAT_CNT_W'(LAT - 1);

  logic [LAT_CNT_W-1:0] r_cnt;

  // First wait-state cycle sees 0, arrival cycle sees LAST.
  always_ff @(posedge i_clk) begin
    if (i_rst)                       r_cnt <= '0;
    else if (i_load)                 r_cnt <= '0;
    else if (i_run && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
  end

  assign o_done = i_run && (r_cnt == LAST);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port data memory between the core MEM stage and the host
//   loader/readback port. Core has priority; a starvation counter forces the
//   host through after STARVE_LIM waiting cycles. Core loads stall the pipeline
//   until data arrives; host ownership stalls any concurrent core access.
//   i_sys_clk : clock
//   i_sys_rst : synchronous active-high reset
//   io_bus    : core / host / memory signals (slave modport)
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 8
) (
  input logic               i_sys_clk,
  input logic               i_sys_rst,
  dmem_port_arbiter_if.slave io_bus
);
  localparam int SC_W = $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0] SC_LIM = SC_W'(STARVE_LIM);

  arb_state_e          r_state, w_state_nxt;
  logic [SC_W-1:0]     r_starve_cnt;

  logic                w_core_req, w_host_win, w_load, w_run, w_done;
  logic                w_stall, w_gnt, w_rvalid;
  logic                w_mem_en, w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [WORD_LEN-1:0] w_mem_wdata, w_core_rdata, w_host_rdata;

  assign w_core_req = io_bus.i_core_rd_en | io_bus.i_core_wr_en;
  assign w_host_win = io_bus.i_host_req & (~w_core_req | (r_starve_cnt == SC_LIM));
  assign w_run      = (r_state == ST_CORE_RD) | (r_state == ST_HOST_RD);

  dmem_lat_counter #(.RD_LAT(RD_LAT)) u_lat (
    .i_clk  (i_sys_clk),
    .i_rst  (i_sys_rst),
    .i_load (w_load),
    .i_run  (w_run),
    .o_done (w_done)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst)                                     r_starve_cnt <= '0;
    else if (w_gnt)                                    r_starve_cnt <= '0;
    else if (io_bus.i_host_req && r_starve_cnt != SC_LIM) r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_stall      = 1'b0;
    w_gnt        = 1'b0;
    w_rvalid     = 1'b0;
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_core_rdata = '0;
    w_host_rdata = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_host_win) begin
          w_gnt      = 1'b1;
          w_stall    = w_core_req;  // core waits while the host holds the port
          w_mem_en   = 1'b1;
          w_mem_we   = io_bus.i_host_we;
          w_mem_addr = io_bus.i_host_addr;
          if (io_bus.i_host_we) begin
            w_mem_wdata = io_bus.i_host_wdata;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_HOST_RD;
          end
        end else if (w_core_req) begin
          w_mem_en   = 1'b1;
          w_mem_we   = io_bus.i_core_wr_en;
          w_mem_addr = io_bus.i_core_addr;
          if (io_bus.i_core_wr_en) begin
            w_mem_wdata = io_bus.i_core_wdata;
          end else begin
            w_stall     = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = ST_CORE_RD;
          end
        end
      end
      ST_CORE_RD: begin
        // Stall drops in the arrival cycle so MEM/WB captures the load data.
        if (w_done) begin
          w_core_rdata = io_bus.i_mem_rdata;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_HOST_RD: begin
        w_stall = w_core_req;
        if (w_done) begin
          w_rvalid     = 1'b1;
          w_host_rdata = io_bus.i_mem_rdata;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Everything is forced quiet while reset is held, even though the
  // arbitration logic would otherwise see live requests in IDLE.
  assign io_bus.o_core_stall  = w_stall  & ~i_sys_rst;
  assign io_bus.o_host_gnt    = w_gnt    & ~i_sys_rst;
  assign io_bus.o_host_rvalid = w_rvalid & ~i_sys_rst;
  assign io_bus.o_mem_en      = w_mem_en & ~i_sys_rst;
  assign io_bus.o_mem_we      = w_mem_we & ~i_sys_rst;
  assign io_bus.o_mem_addr    = i_sys_rst ? '0 : w_mem_addr;
  assign io_bus.o_mem_wdata   = i_sys_rst ? '0 : w_mem_wdata;
  assign io_bus.o_core_rdata  = i_sys_rst ? '0 : w_core_rdata;
  assign io_bus.o_host_rdata  = i_sys_rst ? '0 : w_host_rdata;
endmodule
